sdram_port_arb: RTL and testbench

//  Multi-client SDRAM front end between CPU-side byte buses and the toggle-handshake sdram controller port.

---
 rtl/sdram_port_arb.sv | 129 ++++++++++++
 tb/tb_sdram_port_arb.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_port_arb.sv
// sdram_port_arb: detects client access starts, keeps one request slot per client and
// round-robins them onto a single toggle-handshake SDRAM controller port.
module sdram_port_arb #(
    parameter int NPORTS    = 2,
    parameter int AW        = 16,
    parameter bit RD_RETRIG = 1'b1
) (
    input  logic                 clk,
    input  logic                 init_n,
    input  logic [NPORTS-1:0]    cli_cs,
    input  logic [NPORTS-1:0]    cli_oe,
    input  logic [NPORTS-1:0]    cli_we,
    input  logic [NPORTS*AW-1:0] cli_a,
    input  logic [NPORTS*8-1:0]  cli_d,
    output logic [NPORTS*8-1:0]  cli_q,
    output logic [NPORTS-1:0]    cli_busy,
    output logic                 sd_req,
    input  logic                 sd_ack,
    output logic [AW-1:0]        sd_a,
    output logic [1:0]           sd_ds,
    output logic                 sd_we,
    output logic [15:0]          sd_d,
    input  logic [15:0]          sd_q
);
    localparam int PW = NPORTS > 1 ? $clog2(NPORTS) : 1;

    if (NPORTS < 1 || NPORTS > 4) begin : g_bad_nports
        $error("sdram_port_arb: NPORTS must be 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nx;
    logic [NPORTS-1:0] rd, wr, rd_h, wr_h, start, pend, slot_we;
    logic [AW-1:0]     a_h    [NPORTS];
    logic [AW-1:0]     slot_a [NPORTS];
    logic [7:0]        slot_d [NPORTS];
    logic [PW-1:0]     rr, g, gnt;
    logic              gnt_ok;

    assign rd = cli_cs & cli_oe;
    assign wr = cli_cs & cli_we;

    always_comb begin
        start = '0;
        for (int p = 0; p < NPORTS; p++)
            start[p] = (rd[p] && !rd_h[p]) || (wr[p] && !wr_h[p]) ||
                       (RD_RETRIG && rd[p] && cli_a[p*AW +: AW] != a_h[p]);
    end

    // Scan downwards so the last hit is the first pending port at or after rr.
    always_comb begin
        gnt_ok = 1'b0;
        gnt    = '0;
        for (int i = NPORTS - 1; i >= 0; i--) begin
            if (pend[(int'(rr) + i) % NPORTS]) begin
                gnt_ok = 1'b1;
                gnt    = PW'((int'(rr) + i) % NPORTS);
            end
        end
    end

    always_comb begin
        state_nx = state == IDLE  ? (gnt_ok ? ISSUE : IDLE) :
                   state == ISSUE ? WAIT :
                   state == WAIT  ? (sd_ack == sd_req ? DONE : WAIT) : IDLE;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk or negedge init_n) begin
        if (!init_n) begin
            rd_h     <= '0;
            wr_h     <= '0;
            pend     <= '0;
            slot_we  <= '0;
            cli_busy <= '0;
            cli_q    <= '0;
            rr       <= '0;
            g        <= '0;
            sd_req   <= 1'b0;
            sd_a     <= '0;
            sd_ds    <= '0;
            sd_we    <= 1'b0;
            sd_d     <= '0;
            for (int p = 0; p < NPORTS; p++) begin
                a_h[p]    <= '0;
                slot_a[p] <= '0;
                slot_d[p] <= '0;
            end
        end else begin
            rd_h <= rd;
            wr_h <= wr;
            for (int p = 0; p < NPORTS; p++)
                a_h[p] <= cli_a[p*AW +: AW];
            if (state == IDLE && gnt_ok) begin
                g         <= gnt;
                sd_a      <= slot_a[gnt];
                sd_we     <= slot_we[gnt];
                sd_d      <= {2{slot_d[gnt]}};
                sd_ds     <= slot_we[gnt] ? {slot_a[gnt][0], ~slot_a[gnt][0]} : 2'b11;
                pend[gnt] <= 1'b0;
            end
            if (state == ISSUE)
                sd_req <= ~sd_req;
            if (state == DONE) begin
                if (!sd_we)
                    cli_q[int'(g)*8 +: 8] <= sd_a[0] ? sd_q[15:8] : sd_q[7:0];
                cli_busy[g] <= pend[g];
                rr          <= PW'((int'(g) + 1) % NPORTS);
            end
            // A new start overrides the grant/done updates above: set wins.
            for (int p = 0; p < NPORTS; p++) begin
                if (start[p]) begin
                    slot_a[p]   <= cli_a[p*AW +: AW];
                    slot_d[p]   <= cli_d[p*8 +: 8];
                    slot_we[p]  <= wr[p];
                    pend[p]     <= 1'b1;
                    cli_busy[p] <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_sdram_port_arb.sv
// tb_sdram_port_arb: directed and randomized checks of sdram_port_arb against a byte-memory
// and round-robin reference model; instance 0 retriggers on address change, instance 1 does not.
module tb_sdram_port_arb;
    typedef struct packed {
        logic [15:0] a;
        logic        we;
        logic [1:0]  ds;
        logic [15:0] d;
    } rq_t;

    logic        clk, init_n;
    logic [1:0]  cs, oe, we;
    logic [31:0] ca;
    logic [15:0] cd;
    int          ack_dly;
    logic        force_q;
    logic [15:0] force_val;
    int          inj_req;
    int          vectors, miscompares, mrr;
    logic [7:0]  ref_mem [65536];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar k = 0; k < 2; k++) begin : g_i
        logic [15:0] cq, sa, sd, sq;
        logic [1:0]  busy, ds;
        logic        req, ack, swe;
        rq_t         log [$];
        logic [7:0]  mem [65536];
        logic        seen, busyc, filled;
        int          cnt, inj_done;

        sdram_port_arb #(.NPORTS(2), .AW(16), .RD_RETRIG(k == 0)) dut (
            .clk(clk), .init_n(init_n), .cli_cs(cs), .cli_oe(oe), .cli_we(we),
            .cli_a(ca), .cli_d(cd), .cli_q(cq), .cli_busy(busy), .sd_req(req),
            .sd_ack(ack), .sd_a(sa), .sd_ds(ds), .sd_we(swe), .sd_d(sd), .sd_q(sq)
        );

        initial begin
            filled = 1'b0;
            ack    = 1'b0;
            sq     = '0;
        end

        // Controller model: honours byte enables, acks a programmable delay after each new toggle.
        always @(negedge clk) begin
            if (!filled) begin
                for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 29 + 7);
                filled = 1'b1;
            end
            if (!init_n) begin
                seen = 1'b0; busyc = 1'b0; cnt = 0; ack = 1'b0;
                inj_done = (k == 0) ? inj_req : 0;
            end else if (k == 0 && inj_req != inj_done) begin
                ack = ~ack;
                inj_done = inj_req;
            end else if (busyc) begin
                if (cnt == 0) begin
                    ack = seen;
                    busyc = 1'b0;
                end else cnt--;
            end else if (req !== seen) begin
                seen = req;
                log.push_back('{a: sa, we: swe, ds: ds, d: sd});
                if (swe) begin
                    if (ds[1]) mem[{sa[15:1], 1'b1}] = sd[15:8];
                    if (ds[0]) mem[{sa[15:1], 1'b0}] = sd[7:0];
                end
                sq = force_q ? force_val : {mem[{sa[15:1], 1'b1}], mem[{sa[15:1], 1'b0}]};
                cnt = ack_dly;
                busyc = 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input int p, input bit w, input logic [15:0] adr, input logic [7:0] dat);
        cs[p] = 1'b1;
        ca[p*16 +: 16] = adr;
        cd[p*8 +: 8] = dat;
        if (w) we[p] = 1'b1;
        else oe[p] = 1'b1;
    endtask

    task automatic release_all();
        cs = '0; oe = '0; we = '0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((g_i[0].busy | g_i[1].busy) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(n < 400), 1);
    endtask

    // Issue accesses on the masked ports in one cycle; expected order follows the model rr pointer.
    task automatic batch(input logic [1:0] mask, input logic [1:0] w, input logic [31:0] adr, input logic [15:0] dat);
        int b, p;
        int order [$];
        logic [7:0] expq [2];
        logic [15:0] pa;
        rq_t r;
        b = g_i[0].log.size();
        for (int i = 0; i < 2; i++) if (mask[i]) access(i, w[i], adr[i*16 +: 16], dat[i*8 +: 8]);
        @(negedge clk);
        release_all();
        wait_idle();
        if (mask == 2'b11) order = '{mrr, (mrr + 1) % 2};
        else order = '{mask[0] ? 0 : 1};
        chk("batch_count", 32'(g_i[0].log.size() - b), 32'(order.size()));
        expq = '{8'h0, 8'h0};
        for (int i = 0; i < order.size(); i++) begin
            p  = order[i];
            pa = adr[p*16 +: 16];
            r  = g_i[0].log[b + i];
            chk("batch_addr", 32'(r.a), 32'(pa));
            chk("batch_we", 32'(r.we), 32'(w[p]));
            chk("batch_ds", 32'(r.ds), w[p] ? {30'b0, pa[0], ~pa[0]} : 32'd3);
            if (w[p]) begin
                chk("batch_wdata", 32'(r.d), {16'b0, dat[p*8 +: 8], dat[p*8 +: 8]});
                ref_mem[pa] = dat[p*8 +: 8];
            end else expq[p] = ref_mem[pa];
            mrr = (p + 1) % 2;
        end
        for (int i = 0; i < 2; i++)
            if (mask[i] && !w[i]) chk("batch_rdata", 32'(g_i[0].cq[i*8 +: 8]), 32'(expq[i]));
    endtask

    initial begin
        int b0, b1, n;
        logic [7:0] q1_old;
        vectors = 0; miscompares = 0; mrr = 0; inj_req = 0;
        cs = '0; oe = '0; we = '0; ca = '0; cd = '0;
        init_n = 1'b0; ack_dly = 4; force_q = 1'b0; force_val = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'(i * 29 + 7);
        repeat (3) @(negedge clk);
        chk("rst_req", 32'(g_i[0].req), 0);
        chk("rst_sd_a", 32'(g_i[0].sa), 0);
        chk("rst_ds_we_d", {13'b0, g_i[0].ds, g_i[0].swe, g_i[0].sd}, 0);
        chk("rst_cli_q", 32'(g_i[0].cq), 0);
        chk("rst_busy", 32'(g_i[0].busy), 0);
        init_n = 1'b1;
        @(negedge clk);

        // Port 0 read of odd byte; request toggle lands on the third edge after the start.
        force_q = 1'b1; force_val = 16'hAB12;
        b0 = g_i[0].log.size();
        access(0, 0, 16'h1235, 8'h00);
        repeat (2) @(negedge clk);
        chk("lat_before", 32'(g_i[0].req), 0);
        @(negedge clk);
        chk("lat_toggle", 32'(g_i[0].req), 1);
        release_all();
        wait_idle();
        force_q = 1'b0;
        chk("t1_count", 32'(g_i[0].log.size() - b0), 1);
        chk("t1_addr", 32'(g_i[0].log[b0].a), 32'h1235);
        chk("t1_ds", 32'(g_i[0].log[b0].ds), 3);
        chk("t1_we", 32'(g_i[0].log[b0].we), 0);
        chk("t1_req_once", 32'(g_i[0].req), 1);
        chk("t1_q0", 32'(g_i[0].cq[7:0]), 32'hAB);
        chk("t1_busy0", 32'(g_i[0].busy[0]), 0);
        mrr = 1;

        // Port 1 byte write at even address; its read byte must not move.
        q1_old = g_i[0].cq[15:8];
        batch(2'b10, 2'b10, {16'h0040, 16'h0000}, {8'h5A, 8'h00});
        chk("t2_q1_kept", 32'(g_i[0].cq[15:8]), 32'(q1_old));

        // Ties rotate: rr=0 serves port 0 first; after a lone port-0 access, port 1 goes first.
        batch(2'b11, 2'b00, {16'h0201, 16'h0100}, 16'h0);
        batch(2'b01, 2'b00, {16'h0000, 16'h0102}, 16'h0);
        batch(2'b11, 2'b00, {16'h0203, 16'h0104}, 16'h0);

        // Address walk with oe held while the first read is in flight.
        ack_dly = 10;
        b0 = g_i[0].log.size();
        b1 = g_i[1].log.size();
        cs[0] = 1'b1; oe[0] = 1'b1; ca[15:0] = 16'h0010;
        @(negedge clk); ca[15:0] = 16'h0011;
        @(negedge clk); ca[15:0] = 16'h0012;
        @(negedge clk);
        wait_idle();
        release_all();
        @(negedge clk);
        chk("t4_retrig_count", 32'(g_i[0].log.size() - b0), 2);
        chk("t4_retrig_first", 32'(g_i[0].log[b0].a), 32'h0010);
        chk("t4_retrig_last", 32'(g_i[0].log[b0 + 1].a), 32'h0012);
        chk("t4_retrig_q0", 32'(g_i[0].cq[7:0]), 32'(ref_mem[16'h0012]));
        chk("t5_noretrig_count", 32'(g_i[1].log.size() - b1), 1);
        chk("t5_noretrig_addr", 32'(g_i[1].log[b1].a), 32'h0010);
        chk("t5_noretrig_q0", 32'(g_i[1].cq[7:0]), 32'(ref_mem[16'h0010]));
        mrr = 1;

        // Reset during WAIT clears everything asynchronously; stray acks while idle do nothing.
        ack_dly = 20;
        access(0, 0, 16'h0300, 8'h00);
        @(negedge clk);
        release_all();
        n = 0;
        while (g_i[0].req === g_i[0].ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_flight", 32'(g_i[0].busy[0]), 1);
        #2 init_n = 1'b0;
        #1;
        chk("t6_rst_req", 32'(g_i[0].req), 0);
        chk("t6_rst_sd", {g_i[0].sa, 13'b0, g_i[0].ds, g_i[0].swe}, 0);
        chk("t6_rst_d", 32'(g_i[0].sd), 0);
        chk("t6_rst_q", 32'(g_i[0].cq), 0);
        chk("t6_rst_busy", 32'(g_i[0].busy), 0);
        repeat (2) @(negedge clk);
        init_n = 1'b1;
        mrr = 0;
        @(negedge clk);
        inj_req++;
        repeat (3) @(negedge clk);
        chk("t6_stray_busy", 32'(g_i[0].busy), 0);
        chk("t6_stray_req", 32'(g_i[0].req), 0);
        chk("t6_stray_q", 32'(g_i[0].cq), 0);
        inj_req++;
        repeat (3) @(negedge clk);
        ack_dly = 3;
        batch(2'b10, 2'b00, {16'h0305, 16'h0000}, 16'h0);

        // Random mixes of single and simultaneous accesses over a small address window.
        repeat (40) begin
            ack_dly = $urandom_range(0, 5);
            batch(2'($urandom_range(1, 3)), 2'($urandom_range(0, 3)),
                  {16'($urandom_range(0, 255)), 16'($urandom_range(0, 255))}, 16'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: simulation did not finish");
    end
endmodule
